// File: rtl/uart_move_parser.sv
// ---------------------------------------------------------------------------
// uart_move_parser
//
// Pulls bytes out of the UART receive FIFO and assembles 4-byte Gobang move
// frames: header, X, Y, checksum.  The checksum byte is the 8-bit XOR of the
// other three.  A frame that checks out and lies on the board is offered to
// the game logic with a valid/ready handshake.  A frame is rejected if the
// checksum is wrong, if a coordinate is off the board, or if the gap between
// bytes is too long.  A rejected frame raises a one-cycle error pulse and is
// counted.
//
// Ports
//   sys_clk     in   system clock, all logic on the rising edge
//   sys_rst_n   in   asynchronous active-low reset
//   rxd_data    in   [7:0] FIFO read data, valid the cycle after rxd_rd_en
//   rxd_empty   in   FIFO empty flag
//   rxd_rd_en   out  FIFO read strobe, single-cycle pulse
//   move_x      out  [3:0] column of the accepted move
//   move_y      out  [3:0] row of the accepted move
//   move_valid  out  move_x/move_y valid, held until move_ready
//   move_ready  in   consumer takes the move when move_valid & move_ready
//   frame_err   out  one-cycle pulse on a rejected frame
//   err_code    out  [1:0] last error cause: 1 checksum, 2 range, 3 timeout
//   err_cnt     out  [7:0] rejected-frame count, saturates at 255
// ---------------------------------------------------------------------------
module uart_move_parser #(
  parameter int          CLK_FREQ   = 100000000,
  parameter int          TIMEOUT_US = 1000,
  parameter int          BOARD_SIZE = 15,
  parameter logic [7:0]  HDR_BYTE   = 8'hAA
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] rxd_data,
  input  logic       rxd_empty,
  output logic       rxd_rd_en,
  output logic [3:0] move_x,
  output logic [3:0] move_y,
  output logic       move_valid,
  input  logic       move_ready,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [7:0] err_cnt
);

  localparam int TIMEOUT_CYCLES = (CLK_FREQ / 1000000) * TIMEOUT_US;
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       BOARD_LIM = 8'(BOARD_SIZE);

  localparam logic [2:0] S_HDR = 3'd0;
  localparam logic [2:0] S_X   = 3'd1;
  localparam logic [2:0] S_Y   = 3'd2;
  localparam logic [2:0] S_SUM = 3'd3;
  localparam logic [2:0] S_OUT = 3'd4;

  localparam logic [1:0] ERR_SUM   = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_TIME  = 2'd3;

  logic [1:0]       rst_sync;
  logic             rst_n_int;
  logic [2:0]       state;
  logic             byte_vld;
  logic [7:0]       x_reg;
  logic [7:0]       y_reg;
  logic [CNT_W-1:0] to_cnt;
  logic             in_frame;
  logic             timeout_hit;
  logic             sum_ok;
  logic             range_ok;
  logic             err_fire;
  logic [1:0]       err_kind;

  // Reset asserts immediately but is released only on a clock edge, so
  // every register leaves reset in the same cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync[1];

  // A read is issued only when nothing is in flight (byte_vld marks the
  // cycle the previous read's data is on rxd_data), so strobes can never be
  // back to back.  Reads stop while a move waits for the consumer.
  always_comb begin
    rxd_rd_en = rst_n_int & ~rxd_empty & (state != S_OUT) & ~byte_vld;
  end

  // Frame checks and error selection.  A byte arriving in the same cycle as
  // the timeout limit is processed and suppresses the timeout.  A bad
  // checksum is reported in preference to a range error.
  always_comb begin
    in_frame    = (state == S_X) || (state == S_Y) || (state == S_SUM);
    timeout_hit = in_frame && !byte_vld && (to_cnt == CNT_LAST);
    sum_ok      = (rxd_data == (HDR_BYTE ^ x_reg ^ y_reg));
    range_ok    = (x_reg < BOARD_LIM) && (y_reg < BOARD_LIM);
    err_fire    = 1'b0;
    err_kind    = 2'd0;
    if (timeout_hit) begin
      err_fire = 1'b1;
      err_kind = ERR_TIME;
    end else if ((state == S_SUM) && byte_vld && !sum_ok) begin
      err_fire = 1'b1;
      err_kind = ERR_SUM;
    end else if ((state == S_SUM) && byte_vld && !range_ok) begin
      err_fire = 1'b1;
      err_kind = ERR_RANGE;
    end
  end

  // byte_vld follows the read strobe by one cycle.  Clearing it in reset
  // drops any read that was outstanding when reset hit.
  always_ff @(posedge sys_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      byte_vld <= 1'b0;
    end else begin
      byte_vld <= rxd_rd_en;
    end
  end

  // Inter-byte gap counter.  It only runs while a frame is partly received
  // and restarts on every byte.
  always_ff @(posedge sys_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      to_cnt <= '0;
    end else if (byte_vld || !in_frame || timeout_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Frame FSM.  A header value seen in the X or Y slot is plain data, not a
  // resync.  Any error sends the FSM back to header hunting.
  always_ff @(posedge sys_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state  <= S_HDR;
      x_reg  <= 8'd0;
      y_reg  <= 8'd0;
      move_x <= 4'd0;
      move_y <= 4'd0;
    end else if (err_fire) begin
      state <= S_HDR;
    end else begin
      case (state)
        S_HDR: begin
          if (byte_vld && (rxd_data == HDR_BYTE)) begin
            state <= S_X;
          end
        end
        S_X: begin
          if (byte_vld) begin
            x_reg <= rxd_data;
            state <= S_Y;
          end
        end
        S_Y: begin
          if (byte_vld) begin
            y_reg <= rxd_data;
            state <= S_SUM;
          end
        end
        S_SUM: begin
          if (byte_vld) begin
            move_x <= x_reg[3:0];
            move_y <= y_reg[3:0];
            state  <= S_OUT;
          end
        end
        S_OUT: begin
          if (move_ready) begin
            state <= S_HDR;
          end
        end
        default: begin
          state <= S_HDR;
        end
      endcase
    end
  end

  assign move_valid = (state == S_OUT);

  // Error reporting: the pulse, the cause and the count all change together
  // in the cycle after the failing byte (or the expired gap).
  always_ff @(posedge sys_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      frame_err <= 1'b0;
      err_code  <= 2'd0;
      err_cnt   <= 8'd0;
    end else begin
      frame_err <= err_fire;
      if (err_fire) begin
        err_code <= err_kind;
        if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_move_parser.sv
// ---------------------------------------------------------------------------
// tb_uart_move_parser
//
// Drives uart_move_parser from a queue-based model of a standard-mode FIFO.
// Expected results come from a frame-level reference model that applies the
// frame rules directly to each transmitted frame.  Observed moves and errors
// are logged as events and compared to the expected event list.
// Event encoding: [9:8] = 0 for a move ({x,y} in [7:0]), else error code.
// ---------------------------------------------------------------------------
module tb_uart_move_parser;

  localparam int TCLK_FREQ   = 10000000;
  localparam int TTIMEOUT_US = 1;
  localparam int TCYC        = (TCLK_FREQ / 1000000) * TTIMEOUT_US;

  logic       sys_clk    = 1'b0;
  logic       sys_rst_n  = 1'b0;
  logic [7:0] rxd_data   = 8'h00;
  logic       rxd_empty  = 1'b1;
  logic       rxd_rd_en;
  logic [3:0] move_x;
  logic [3:0] move_y;
  logic       move_valid;
  logic       move_ready = 1'b0;
  logic       frame_err;
  logic [1:0] err_code;
  logic [7:0] err_cnt;

  int checks = 0;
  int failures = 0;
  int exp_err_cnt = 0;
  int cyc = 0;
  int last_rd = -1;
  int rd_count = 0;
  int rd_consec = 0;
  int rd_in_out = 0;
  logic rd_prev = 1'b0;

  logic [7:0] fifo_q[$];
  logic [9:0] obs_q[$];
  logic [9:0] exp_q[$];

  uart_move_parser #(
    .CLK_FREQ(TCLK_FREQ),
    .TIMEOUT_US(TTIMEOUT_US),
    .BOARD_SIZE(15),
    .HDR_BYTE(8'hAA)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .rxd_data(rxd_data),
    .rxd_empty(rxd_empty),
    .rxd_rd_en(rxd_rd_en),
    .move_x(move_x),
    .move_y(move_y),
    .move_valid(move_valid),
    .move_ready(move_ready),
    .frame_err(frame_err),
    .err_code(err_code),
    .err_cnt(err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // FIFO model: a strobe seen before the edge returns the head byte after it.
  always @(posedge sys_clk) begin
    logic [7:0] tmp;
    if (rxd_rd_en && fifo_q.size() > 0) begin
      tmp = fifo_q.pop_front();
      rxd_data <= tmp;
    end
    rxd_empty <= (fifo_q.size() == 0);
  end

  // Event logger and protocol monitor.
  always @(posedge sys_clk) begin
    if (rxd_rd_en) begin
      rd_count = rd_count + 1;
      last_rd = cyc;
      if (rd_prev) rd_consec = rd_consec + 1;
      if (move_valid) rd_in_out = rd_in_out + 1;
    end
    rd_prev = rxd_rd_en;
    if (move_valid && move_ready) obs_q.push_back({2'b00, move_x, move_y});
    if (frame_err) obs_q.push_back({err_code, 8'h00});
    cyc = cyc + 1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: the outcome of one frame from its three payload bytes.
  function automatic logic [9:0] model_frame(input logic [7:0] x, input logic [7:0] y,
                                             input logic [7:0] s);
    if (s != (8'hAA ^ x ^ y)) return {2'd1, 8'h00};
    if (x >= 8'd15 || y >= 8'd15) return {2'd2, 8'h00};
    return {2'd0, x[3:0], y[3:0]};
  endfunction

  task automatic expect_event(input logic [9:0] ev);
    exp_q.push_back(ev);
    if (ev[9:8] != 2'd0 && exp_err_cnt < 255) exp_err_cnt = exp_err_cnt + 1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic push_frame(input logic [7:0] x, input logic [7:0] y, input logic [7:0] s);
    push_byte(8'hAA);
    push_byte(x);
    push_byte(y);
    push_byte(s);
    expect_event(model_frame(x, y, s));
  endtask

  task automatic wait_events(input int n, input int budget);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      @(negedge sys_clk);
      k++;
    end
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic start_test;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    move_ready = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks += 7;
    if (move_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b want 0", move_valid); end
    if (move_x !== 4'd0) begin failures++; $display("[TB] FAIL reset_x: got %h want 0", move_x); end
    if (move_y !== 4'd0) begin failures++; $display("[TB] FAIL reset_y: got %h want 0", move_y); end
    if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b want 0", frame_err); end
    if (err_code !== 2'd0) begin failures++; $display("[TB] FAIL reset_code: got %h want 0", err_code); end
    if (err_cnt !== 8'd0) begin failures++; $display("[TB] FAIL reset_cnt: got %h want 0", err_cnt); end
    if (rxd_rd_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd: got %b want 0", rxd_rd_en); end
    sys_rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic test_basic;
    int base;
    start_test();
    move_ready = 1'b1;
    base = rd_count;
    push_frame(8'h03, 8'h07, 8'hAE);
    wait_events(1, 60);
    checks += 4;
    if (obs_q.size() != 1) begin failures++; $display("[TB] FAIL basic_events: got %0d want 1", obs_q.size()); end
    if (obs_q[0] !== exp_q[0]) begin failures++; $display("[TB] FAIL basic_move: got %h want %h", obs_q[0], exp_q[0]); end
    if (rd_count - base != 4) begin failures++; $display("[TB] FAIL basic_reads: got %0d want 4", rd_count - base); end
    if (err_cnt !== 8'(exp_err_cnt)) begin failures++; $display("[TB] FAIL basic_errcnt: got %0d want %0d", err_cnt, exp_err_cnt); end
  endtask

  task automatic test_hold;
    int k;
    int bad;
    int base;
    start_test();
    move_ready = 1'b0;
    push_byte(8'h55);
    push_byte(8'h12);
    push_frame(8'h00, 8'h00, 8'hAA);
    k = 0;
    while (move_valid !== 1'b1 && k < 60) begin @(negedge sys_clk); k++; end
    checks++;
    if (move_valid !== 1'b1) begin failures++; $display("[TB] FAIL hold_rise: got %b want 1", move_valid); end
    push_frame(8'h05, 8'h05, 8'hAA);
    base = rd_count;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (!(move_valid === 1'b1 && move_x === 4'd0 && move_y === 4'd0)) bad++;
    end
    checks += 2;
    if (bad != 0) begin failures++; $display("[TB] FAIL hold_stable: got %0d unstable cycles want 0", bad); end
    if (rd_count != base) begin failures++; $display("[TB] FAIL hold_reads: got %0d reads want 0", rd_count - base); end
    move_ready = 1'b1;
    @(negedge sys_clk);
    checks++;
    if (move_valid !== 1'b0) begin failures++; $display("[TB] FAIL hold_drop: got %b want 0", move_valid); end
    wait_events(2, 60);
    checks += 3;
    if (obs_q.size() != 2) begin failures++; $display("[TB] FAIL hold_events: got %0d want 2", obs_q.size()); end
    if (obs_q[0] !== exp_q[0]) begin failures++; $display("[TB] FAIL hold_move0: got %h want %h", obs_q[0], exp_q[0]); end
    if (obs_q[1] !== exp_q[1]) begin failures++; $display("[TB] FAIL hold_move1: got %h want %h", obs_q[1], exp_q[1]); end
  endtask

  task automatic test_checksum;
    start_test();
    move_ready = 1'b1;
    push_frame(8'h03, 8'h07, 8'h00);
    push_frame(8'h01, 8'h01, 8'hAA);
    wait_events(2, 80);
    checks += 5;
    if (obs_q.size() != 2) begin failures++; $display("[TB] FAIL sum_events: got %0d want 2", obs_q.size()); end
    if (obs_q[0] !== exp_q[0]) begin failures++; $display("[TB] FAIL sum_err: got %h want %h", obs_q[0], exp_q[0]); end
    if (obs_q[1] !== exp_q[1]) begin failures++; $display("[TB] FAIL sum_next_move: got %h want %h", obs_q[1], exp_q[1]); end
    if (err_code !== 2'd1) begin failures++; $display("[TB] FAIL sum_code: got %0d want 1", err_code); end
    if (err_cnt !== 8'(exp_err_cnt)) begin failures++; $display("[TB] FAIL sum_errcnt: got %0d want %0d", err_cnt, exp_err_cnt); end
  endtask

  task automatic test_range;
    start_test();
    move_ready = 1'b1;
    push_frame(8'h0F, 8'h02, 8'hA7);
    wait_events(1, 60);
    checks += 3;
    if (obs_q[0] !== exp_q[0] || obs_q.size() != 1) begin failures++; $display("[TB] FAIL range_err: got %h (n=%0d) want %h", obs_q[0], obs_q.size(), exp_q[0]); end
    if (err_code !== 2'd2) begin failures++; $display("[TB] FAIL range_code: got %0d want 2", err_code); end
    if (err_cnt !== 8'(exp_err_cnt)) begin failures++; $display("[TB] FAIL range_errcnt: got %0d want %0d", err_cnt, exp_err_cnt); end
  endtask

  task automatic test_timeout;
    int base;
    int b;
    int k;
    int early;
    // Run 1: the frame stalls after X and must time out.
    start_test();
    move_ready = 1'b1;
    base = rd_count;
    push_byte(8'hAA);
    push_byte(8'h03);
    k = 0;
    while (rd_count < base + 2 && k < 40) begin @(negedge sys_clk); k++; end
    b = last_rd + 1;
    while (cyc < b) @(negedge sys_clk);
    early = 0;
    for (int i = 1; i <= TCYC; i++) begin
      @(negedge sys_clk);
      if (frame_err !== 1'b0) early++;
    end
    @(negedge sys_clk);
    if (exp_err_cnt < 255) exp_err_cnt++;
    checks += 4;
    if (early != 0) begin failures++; $display("[TB] FAIL timeout_early: got %0d early pulses want 0", early); end
    if (frame_err !== 1'b1) begin failures++; $display("[TB] FAIL timeout_pulse: got %b want 1", frame_err); end
    if (err_code !== 2'd3) begin failures++; $display("[TB] FAIL timeout_code: got %0d want 3", err_code); end
    if (err_cnt !== 8'(exp_err_cnt)) begin failures++; $display("[TB] FAIL timeout_errcnt: got %0d want %0d", err_cnt, exp_err_cnt); end
    repeat (3) @(negedge sys_clk);
    // Run 2: the Y byte lands exactly on the limit cycle and wins.
    start_test();
    base = rd_count;
    push_byte(8'hAA);
    push_byte(8'h03);
    k = 0;
    while (rd_count < base + 2 && k < 40) begin @(negedge sys_clk); k++; end
    b = last_rd + 1;
    while (cyc < b + TCYC - 2) @(negedge sys_clk);
    push_byte(8'h04);
    push_byte(8'hAD);
    expect_event(model_frame(8'h03, 8'h04, 8'hAD));
    while (cyc < b + TCYC) @(negedge sys_clk);
    checks++;
    if (last_rd != b + TCYC - 1) begin failures++; $display("[TB] FAIL timeout_align: got rd cycle %0d want %0d", last_rd, b + TCYC - 1); end
    wait_events(1, 40);
    checks += 2;
    if (obs_q.size() != 1) begin failures++; $display("[TB] FAIL timeout_edge_events: got %0d want 1", obs_q.size()); end
    if (obs_q[0] !== exp_q[0]) begin failures++; $display("[TB] FAIL timeout_edge_move: got %h want %h", obs_q[0], exp_q[0]); end
  endtask

  task automatic test_random;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] s;
    logic [7:0] j;
    int kind;
    int k;
    start_test();
    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 3);
      x = 8'($urandom_range(0, 14));
      y = 8'($urandom_range(0, 14));
      if (kind == 2) begin
        if ($urandom_range(0, 1) == 1) x = 8'($urandom_range(15, 255));
        else y = 8'($urandom_range(15, 255));
      end
      s = 8'hAA ^ x ^ y;
      if (kind == 1) begin
        x = 8'($urandom_range(0, 255));
        s = (8'hAA ^ x ^ y) ^ 8'($urandom_range(1, 255));
      end
      if (kind == 3) begin
        j = 8'($urandom_range(0, 255));
        if (j == 8'hAA) j = 8'h00;
        push_byte(j);
      end
      push_frame(x, y, s);
    end
    k = 0;
    while (obs_q.size() < exp_q.size() && k < 4000) begin
      @(negedge sys_clk);
      move_ready = ($urandom_range(0, 3) != 0);
      k++;
    end
    move_ready = 1'b1;
    repeat (10) @(negedge sys_clk);
    checks++;
    if (obs_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("[TB] FAIL random_event%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (err_cnt !== 8'(exp_err_cnt)) begin failures++; $display("[TB] FAIL random_errcnt: got %0d want %0d", err_cnt, exp_err_cnt); end
  endtask

  task automatic test_protocol;
    checks += 2;
    if (rd_consec != 0) begin failures++; $display("[TB] FAIL rd_back_to_back: got %0d want 0", rd_consec); end
    if (rd_in_out != 0) begin failures++; $display("[TB] FAIL rd_during_out: got %0d want 0", rd_in_out); end
  endtask

  task automatic test_saturation;
    start_test();
    move_ready = 1'b1;
    for (int f = 0; f < 260; f++) push_frame(8'h00, 8'h00, 8'h00);
    wait_events(260, 4000);
    checks += 3;
    if (obs_q.size() != 260) begin failures++; $display("[TB] FAIL sat_events: got %0d want 260", obs_q.size()); end
    if (err_cnt !== 8'(exp_err_cnt)) begin failures++; $display("[TB] FAIL sat_errcnt: got %0d want %0d", err_cnt, exp_err_cnt); end
    if (err_code !== 2'd1) begin failures++; $display("[TB] FAIL sat_code: got %0d want 1", err_code); end
  endtask

  task automatic test_reset_midframe;
    int base;
    int k;
    start_test();
    move_ready = 1'b1;
    base = rd_count;
    push_byte(8'hAA);
    push_byte(8'h03);
    k = 0;
    while (rd_count < base + 1 && k < 40) begin @(negedge sys_clk); k++; end
    #2;
    sys_rst_n = 1'b0;
    #1;
    fifo_q.delete();
    exp_err_cnt = 0;
    checks += 6;
    if (err_cnt !== 8'd0) begin failures++; $display("[TB] FAIL rst_mid_cnt: got %0d want 0", err_cnt); end
    if (err_code !== 2'd0) begin failures++; $display("[TB] FAIL rst_mid_code: got %0d want 0", err_code); end
    if (move_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_valid: got %b want 0", move_valid); end
    if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_err: got %b want 0", frame_err); end
    if (rxd_rd_en !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_rd: got %b want 0", rxd_rd_en); end
    if (move_x !== 4'd0 || move_y !== 4'd0) begin failures++; $display("[TB] FAIL rst_mid_xy: got %h/%h want 0/0", move_x, move_y); end
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);
    start_test();
    push_frame(8'h02, 8'h09, 8'hA1);
    wait_events(1, 60);
    checks += 3;
    if (obs_q.size() != 1) begin failures++; $display("[TB] FAIL rst_after_events: got %0d want 1", obs_q.size()); end
    if (obs_q[0] !== exp_q[0]) begin failures++; $display("[TB] FAIL rst_after_move: got %h want %h", obs_q[0], exp_q[0]); end
    if (err_cnt !== 8'(exp_err_cnt)) begin failures++; $display("[TB] FAIL rst_after_errcnt: got %0d want %0d", err_cnt, exp_err_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_checksum();
    test_range();
    test_timeout();
    test_random();
    test_protocol();
    test_saturation();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_move_parser.md
Name: uart_move_parser

Overview:
- Consumes bytes from the UART receive FIFO (rxd_data/rxd_empty/rxd_rd_en side of the uart block).
- Assembles 4-byte move frames (header, X, Y, checksum) sent by the host for the Gobang board.
- Validates each frame and presents board coordinates to the game logic with a valid/ready handshake.
- Flags checksum, range and inter-byte timeout errors.

Parameters:
CLK_FREQ, 100000000, sys_clk frequency in Hz
TIMEOUT_US, 1000, max gap between bytes inside one frame, in microseconds
BOARD_SIZE, 15, legal coordinate range is 0..BOARD_SIZE-1
HDR_BYTE, 8'hAA, frame start byte

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst_n  in  1  asynchronous active-low reset
rxd_data  in  8  RX FIFO read data; valid the cycle after rxd_rd_en (standard-mode FIFO)
rxd_empty  in  1  RX FIFO empty
rxd_rd_en  out  1  RX FIFO read strobe, one-cycle pulse
move_x  out  4  column of accepted move
move_y  out  4  row of accepted move
move_valid  out  1  move_x/move_y valid, held until move_ready
move_ready  in  1  consumer accepts move when move_valid&move_ready
frame_err  out  1  one-cycle pulse on a rejected frame
err_code  out  2  cause of last error: 1 checksum, 2 range, 3 timeout; holds until next error
err_cnt  out  8  rejected-frame count, saturates at 255

Behaviour:
- Reset (async assert, sync deassert internally): every output is 0, FSM in S_HDR, timeout counter cleared.
- Fetch:
  - rxd_rd_en asserts only when rxd_empty=0, FSM not in S_OUT, and no read is outstanding.
  - At most one read is outstanding, so rxd_rd_en is never high on two consecutive cycles.
  - byte_vld is internal and high the cycle after rxd_rd_en; rxd_data is sampled on that cycle.
- FSM (advances only on byte_vld, except S_OUT and timeout):
  - S_HDR: byte==HDR_BYTE -> S_X; any other byte is discarded silently, no error.
  - S_X: store X -> S_Y.
  - S_Y: store Y -> S_SUM.
  - S_SUM: checksum ok when byte == HDR_BYTE^X^Y (8-bit XOR).
    - Checksum bad -> frame_err, code 1, -> S_HDR.
    - Checksum ok but X>=BOARD_SIZE or Y>=BOARD_SIZE -> frame_err, code 2, -> S_HDR.
    - Checksum and range ok -> S_OUT.
  - Checksum failure takes priority over range failure.
  - S_OUT: move_valid=1; move_x=X[3:0], move_y=Y[3:0]. On move_valid&move_ready: move_valid=0 next cycle, -> S_HDR.
- Latency:
  - move_valid rises on the cycle after the checksum byte's byte_vld cycle.
  - frame_err pulses on that same cycle.
- Timeout:
  - TIMEOUT_CYCLES = (CLK_FREQ/1000000)*TIMEOUT_US. The counter width holds this value.
  - Counter clears on every byte_vld and whenever the FSM is in S_HDR or S_OUT.
  - In S_X/S_Y/S_SUM the counter increments each cycle. On reaching TIMEOUT_CYCLES-1: frame_err, code 3, -> S_HDR, partial frame dropped.
  - If byte_vld and timeout coincide, the byte wins: it is processed normally and no timeout fires.
- A header byte arriving in S_X/S_Y is treated as data, not as a resync.
- err_cnt increments on every frame_err pulse and stops at 255. err_code updates on the same cycle as the frame_err pulse.
- The RX FIFO may fill while the FSM sits in S_OUT. Overflow there is the upstream block's concern; this block never reads during S_OUT.
- Reset mid-frame or mid-S_OUT: immediate return to reset state. The partial frame is lost and an outstanding read is ignored.

Test Plan:
- Bytes AA 03 07 AE via FIFO, move_ready=1 -> single move_valid with move_x=3, move_y=7; frame_err stays 0; exactly 4 rxd_rd_en pulses.
- Bytes 55 12 AA 00 00 AA, move_ready held 0 for 20 cycles -> 55 and 12 discarded; move_valid high with x=0, y=0 held 20 cycles stable; no reads during hold; drops 1 cycle after move_ready=1.
- Bytes AA 03 07 00 -> frame_err pulse, err_code=1, err_cnt=1, no move_valid; a following AA 01 01 AA is accepted as x=1, y=1.
- Bytes AA 0F 02 A7 (checksum correct, X=15) -> frame_err, err_code=2, err_cnt increments.
- With TIMEOUT_US=1 and CLK_FREQ=10000000, send AA 03 then stall 10 cycles -> frame_err, err_code=3 on the 10th stalled cycle. In a second run the Y byte's byte_vld lands exactly on cycle 10 -> no error, frame continues.
- Force 260 bad-checksum frames -> err_cnt saturates at 255. Assert sys_rst_n=0 mid-frame -> all outputs 0 asynchronously; the next full valid frame is accepted.
